arm_bus_ctrl: RTL and testbench
===============================

ARM_BUS_CTRL -- requirements
Module: arm_bus_ctrl

Interface
- REQ-001 SHALL have parameter RD_LAT, default 2: cycles from rf_rd pulse to rf_rdata valid (legal 1..15).
- REQ-002 SHALL have parameter TMO, default 255: maximum cycles a strobe may stay asserted in an acknowledge state (legal 1..65535).
- REQ-003 SHALL have port clk  in  1: the single clock; all logic rises on clk.
- REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
- REQ-005 SHALL have port bus_as  in  1: address strobe, active high, already synchronized to clk.
- REQ-006 SHALL have port bus_rs_n  in  1: read strobe, active low, synchronized.
- REQ-007 SHALL have port bus_ws_n  in  1: write strobe, active low, synchronized.
- REQ-008 SHALL have port bus_addr  in  24: bus address, synchronized.
- REQ-009 SHALL have port bus_be_n  in  4: byte enables, active low, synchronized.
- REQ-010 SHALL have port bus_din  in  32: write data from the bus, synchronized.
- REQ-011 SHALL have port bus_dout  out  32: read data to the bus pad driver.
- REQ-012 SHALL have port bus_doe  out  1: output enable for bus_dout.
- REQ-013 SHALL have port bus_dtack_n  out  1: transfer acknowledge, active low.
- REQ-014 SHALL have port rf_addr  out  24: latched register address.
- REQ-015 SHALL have port rf_be  out  4: latched byte enables, active high (inverted bus_be_n).
- REQ-016 SHALL have port rf_wdata  out  32: latched write data.
- REQ-017 SHALL have port rf_wr  out  1: one-cycle register write strobe.
- REQ-018 SHALL have port rf_rd  out  1: one-cycle register read strobe.
- REQ-019 SHALL have port rf_rdata  in  32: register-file read data.
- REQ-020 SHALL have port err_cnt  out  8: saturating count of protocol errors.
- REQ-021 SHALL have port busy  out  1: high in every state except IDLE.

Function
- REQ-022 SHALL implement the FSM states IDLE, RD_WAIT, RD_ACK, WR_ACK and HOLD; all outputs SHALL be registered.
- REQ-023 IDLE, bus_as=1, bus_rs_n=0, bus_ws_n=1: latch addr and be into rf_addr/rf_be, pulse rf_rd on the next cycle, go to RD_WAIT.
- REQ-024 IDLE, bus_as=1, bus_ws_n=0, bus_rs_n=1: latch addr, be and din, pulse rf_wr for exactly 1 cycle, assert bus_dtack_n=0 in the same cycle, go to WR_ACK.
- REQ-025 IDLE, bus_as=1 with both strobes low: error; increment err_cnt, issue no rf strobe, go to HOLD.
- REQ-026 RD_WAIT SHALL count RD_LAT cycles after the rf_rd pulse, then capture rf_rdata into bus_dout, set bus_doe=1 and bus_dtack_n=0, and go to RD_ACK.
- REQ-027 Read latency SHALL be exactly RD_LAT+2 cycles from the cycle in which the strobe is sampled low to the first cycle with bus_dtack_n=0.
- REQ-028 RD_ACK/WR_ACK: when the strobe deasserts (strobe=1) or bus_as=0, the next cycle SHALL have bus_doe=0 and bus_dtack_n=1, and the FSM SHALL return to IDLE.
- REQ-029 RD_ACK/WR_ACK: a 16-bit counter SHALL time the cycles spent in the state; reaching TMO increments err_cnt, drops bus_doe and bus_dtack_n, and goes to HOLD.
- REQ-030 HOLD SHALL stay until bus_rs_n=1, bus_ws_n=1 and bus_as=0 are sampled together, then go to IDLE; no rf strobe or acknowledge is issued in HOLD.
- REQ-031 A strobe that stays low after returning to IDLE SHALL NOT start a second transfer; a new transfer requires a high-to-low strobe edge.
- REQ-032 err_cnt SHALL saturate at 255.
- REQ-033 bus_dout SHALL hold its last captured value while bus_doe=0.

Reset
- REQ-034 rst=1 SHALL force IDLE and these output values: bus_doe=0, bus_dtack_n=1, rf_wr=0, rf_rd=0, err_cnt=0, busy=0, and all data/address outputs=0.
- REQ-035 rst asserted mid-transfer SHALL abort it; once rst releases, a strobe that is still low SHALL be handled per REQ-031.

Structure
- REQ-036 The FSM state enumeration and the RD_LAT/TMO defaults SHALL live in the shared package arm_bus_pkg.
- REQ-037 The wait/timeout counter SHALL be the single sub-module cyc_counter (load, enable, terminal-count flag).

Verification
- REQ-038 Write scenario: addr=0x000010, be_n=4'b0000, din=0xDEADBEEF, ws_n held low 10 cycles -> one rf_wr pulse with rf_wdata=0xDEADBEEF and rf_be=4'hF, dtack_n=0 until 1 cycle after ws_n rises.
- REQ-039 Read scenario: RD_LAT=2, rf_rdata=0x12345678 -> dtack_n=0 and bus_doe=1 exactly 4 cycles after rs_n is sampled low, bus_dout=0x12345678.
- REQ-040 Simultaneous-strobe scenario: rs_n=0 and ws_n=0 together -> no rf strobes, err_cnt=1, busy stays high until both strobes return high and bus_as=0.
- REQ-041 Timeout scenario: TMO=8, rs_n held low 50 cycles -> dtack_n rises after 8 cycles in RD_ACK, err_cnt increments, FSM stays in HOLD until rs_n rises, no second rf_rd.
- REQ-042 Reset scenario: rst pulsed during RD_WAIT -> outputs at reset values on the next cycle, and no rf_rd pulse while rs_n remains low afterwards.
- REQ-043 Saturation scenario: 300 error events -> err_cnt=255.

Source files
------------

// File: rtl/arm_bus_pkg.sv
// Shared types, widths and parameter defaults for the bus-to-register-file bridge.
package arm_bus_pkg;

    localparam int unsigned RD_LAT_DEF = 2;
    localparam int unsigned TMO_DEF    = 255;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_ACK,
        WR_ACK,
        HOLD
    } state_e;

    // Register-file request payload latched at the start of a transfer.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } rf_req_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/cyc_counter.sv
// Loadable down-counter with registered terminal-count flag (high when the count is zero).
module cyc_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == '0);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/arm_bus_ctrl.sv
// Bridge from a strobed asynchronous-style bus to a register file: one rf_rd/rf_wr
// pulse per strobe falling edge, acknowledge handshake with timeout and error count.
module arm_bus_ctrl
    import arm_bus_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    parameter int unsigned TMO    = TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_as,
    input  logic              bus_rs_n,
    input  logic              bus_ws_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [BE_W-1:0]   bus_be_n,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_doe,
    output logic              bus_dtack_n,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [BE_W-1:0]   rf_be,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wr,
    output logic              rf_rd,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    // Counter loads: the FSM leaves a counted state on the edge after the count hits zero.
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO - 1);

    state_e            state_q, state_d;
    rf_req_t           rf_q, rf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              dtack_n_q, dtack_n_d;
    logic              rf_wr_q, rf_wr_d;
    logic              rf_rd_q, rf_rd_d;
    logic              busy_q, busy_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              rs_n_prev_q, ws_n_prev_q;
    logic              rd_fall, wr_fall;
    logic              cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0]  cnt_val;

    // Previous strobe levels reset to "low" so a strobe held through reset is not a new edge.
    assign rd_fall = rs_n_prev_q & ~bus_rs_n;
    assign wr_fall = ws_n_prev_q & ~bus_ws_n;

    cyc_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        rf_d      = rf_q;
        dout_d    = dout_q;
        doe_d     = doe_q;
        dtack_n_d = dtack_n_q;
        rf_wr_d   = 1'b0;
        rf_rd_d   = 1'b0;
        err_d     = err_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_as && (rd_fall || wr_fall)) begin
                    if (!bus_rs_n && !bus_ws_n) begin
                        err_d   = sat_inc(err_q);
                        state_d = HOLD;
                    end else if (!bus_rs_n) begin
                        rf_d.addr = bus_addr;
                        rf_d.be   = ~bus_be_n;
                        rf_rd_d   = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = RD_LOAD;
                        state_d   = RD_WAIT;
                    end else begin
                        rf_d.addr  = bus_addr;
                        rf_d.be    = ~bus_be_n;
                        rf_d.wdata = bus_din;
                        rf_wr_d    = 1'b1;
                        dtack_n_d  = 1'b0;
                        cnt_load   = 1'b1;
                        cnt_val    = TMO_LOAD;
                        state_d    = WR_ACK;
                    end
                end
            end

            RD_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    dout_d    = rf_rdata;
                    doe_d     = 1'b1;
                    dtack_n_d = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = TMO_LOAD;
                    state_d   = RD_ACK;
                end
            end

            RD_ACK, WR_ACK: begin
                cnt_en = 1'b1;
                // Master release wins over a timeout landing on the same edge.
                if (!bus_as || ((state_q == RD_ACK) ? bus_rs_n : bus_ws_n)) begin
                    doe_d     = 1'b0;
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_tc) begin
                    err_d     = sat_inc(err_q);
                    doe_d     = 1'b0;
                    dtack_n_d = 1'b1;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (!bus_as && bus_rs_n && bus_ws_n) begin
                    state_d = IDLE;
                end
            end

            default: begin
                doe_d     = 1'b0;
                dtack_n_d = 1'b1;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rf_q        <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            dtack_n_q   <= 1'b1;
            rf_wr_q     <= 1'b0;
            rf_rd_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            rs_n_prev_q <= 1'b0;
            ws_n_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            dtack_n_q   <= dtack_n_d;
            rf_wr_q     <= rf_wr_d;
            rf_rd_q     <= rf_rd_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            rs_n_prev_q <= bus_rs_n;
            ws_n_prev_q <= bus_ws_n;
        end
    end

    assign bus_dout    = dout_q;
    assign bus_doe     = doe_q;
    assign bus_dtack_n = dtack_n_q;
    assign rf_addr     = rf_q.addr;
    assign rf_be       = rf_q.be;
    assign rf_wdata    = rf_q.wdata;
    assign rf_wr       = rf_wr_q;
    assign rf_rd       = rf_rd_q;
    assign err_cnt     = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_arm_bus_ctrl.sv
// Self-checking bench for arm_bus_ctrl: directed table, randomized transactions
// against a transaction-level model, and hand-written corner sequences.
module tb_arm_bus_ctrl;

    localparam int RD_LAT = 2;
    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_as, bus_rs_n, bus_ws_n;
    logic [23:0] bus_addr;
    logic [3:0]  bus_be_n;
    logic [31:0] bus_din, rf_rdata;

    logic [31:0] bus_dout, t_bus_dout;
    logic        bus_doe, t_bus_doe, bus_dtack_n, t_bus_dtack_n;
    logic [23:0] rf_addr, t_rf_addr;
    logic [3:0]  rf_be, t_rf_be;
    logic [31:0] rf_wdata, t_rf_wdata;
    logic        rf_wr, t_rf_wr, rf_rd, t_rf_rd;
    logic [7:0]  err_cnt, t_err_cnt;
    logic        busy, t_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state
    int          exp_err   = 0;
    logic [31:0] exp_dout  = '0;
    logic [31:0] exp_wdata = '0;

    typedef struct {
        int          kind;
        logic [23:0] addr;
        logic [3:0]  be_n;
        logic [31:0] din;
        logic [31:0] rdata;
        int          hold;
        bit          rel_as;
        logic [3:0]  exp_be;
        logic [7:0]  exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    arm_bus_ctrl dut (
        .clk(clk), .rst(rst), .bus_as(bus_as), .bus_rs_n(bus_rs_n), .bus_ws_n(bus_ws_n),
        .bus_addr(bus_addr), .bus_be_n(bus_be_n), .bus_din(bus_din), .bus_dout(bus_dout),
        .bus_doe(bus_doe), .bus_dtack_n(bus_dtack_n), .rf_addr(rf_addr), .rf_be(rf_be),
        .rf_wdata(rf_wdata), .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_rdata(rf_rdata),
        .err_cnt(err_cnt), .busy(busy)
    );

    arm_bus_ctrl #(.RD_LAT(2), .TMO(8)) dut_t (
        .clk(clk), .rst(rst), .bus_as(bus_as), .bus_rs_n(bus_rs_n), .bus_ws_n(bus_ws_n),
        .bus_addr(bus_addr), .bus_be_n(bus_be_n), .bus_din(bus_din), .bus_dout(t_bus_dout),
        .bus_doe(t_bus_doe), .bus_dtack_n(t_bus_dtack_n), .rf_addr(t_rf_addr), .rf_be(t_rf_be),
        .rf_wdata(t_rf_wdata), .rf_wr(t_rf_wr), .rf_rd(t_rf_rd), .rf_rdata(rf_rdata),
        .err_cnt(t_err_cnt), .busy(t_busy)
    );

    task automatic chk1(input string nm, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0b want %0b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got 0x%08h want 0x%08h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        bus_as   = 1'b0;
        bus_rs_n = 1'b1;
        bus_ws_n = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transfer: strobe(s) low for 'hold' sampled edges, then released.
    task automatic run_txn(input int kind, input logic [23:0] a, input logic [3:0] be_n,
                           input logic [31:0] d, input logic [31:0] rd, input int hold,
                           input bit rel_as, input logic [3:0] exp_be);
        int          ack0;
        bit          ack;
        logic [31:0] old_dout;
        old_dout = exp_dout;
        ack0     = (kind == K_RD) ? RD_LAT + 2 : 0;
        if (kind == K_ERR) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        if (kind == K_RD)  exp_dout = rd;
        if (kind == K_WR)  exp_wdata = d;

        bus_addr = a;
        bus_be_n = be_n;
        bus_din  = d;
        rf_rdata = rd;
        bus_as   = 1'b1;
        bus_rs_n = (kind == K_WR);
        bus_ws_n = (kind == K_RD);

        for (int i = 0; i <= hold + 1; i++) begin
            @(posedge clk);
            #1;
            ack = (kind != K_ERR) && (i >= ack0) && (i < hold);
            chk1("rf_rd", i, rf_rd, (kind == K_RD) && (i == 0));
            chk1("rf_wr", i, rf_wr, (kind == K_WR) && (i == 0));
            chk1("dtack_n", i, bus_dtack_n, !ack);
            chk1("doe", i, bus_doe, (kind == K_RD) && ack);
            chk1("busy", i, busy, i < hold);
            chk32("err_cnt", i, 32'(err_cnt), 32'(exp_err));
            chk32("dout", i, bus_dout, ((kind == K_RD) && (i >= ack0)) ? rd : old_dout);
            if (i == 0 && kind != K_ERR) begin
                chk32("rf_addr", i, 32'(rf_addr), 32'(a));
                chk32("rf_be", i, 32'(rf_be), 32'(exp_be));
                chk32("rf_wdata", i, rf_wdata, exp_wdata);
            end
            if (i == hold - 1) begin
                if (kind == K_ERR) begin
                    bus_as = 1'b0; bus_rs_n = 1'b1; bus_ws_n = 1'b1;
                end else if (rel_as) begin
                    bus_as = 1'b0;
                end else begin
                    bus_rs_n = 1'b1; bus_ws_n = 1'b1;
                end
            end
        end
        idle_cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int trd;
        tbl[0] = '{K_WR,  24'h000010, 4'b0000, 32'hDEADBEEF, 32'h0,        10, 1'b0, 4'hF, 8'd0, 32'hCAFE0001};
        tbl[1] = '{K_RD,  24'h000010, 4'b0000, 32'h0,        32'h12345678,  8, 1'b0, 4'hF, 8'd0, 32'h12345678};
        tbl[2] = '{K_RD,  24'hFFFFFF, 4'b1010, 32'h0,        32'hA5A55A5A,  5, 1'b1, 4'h5, 8'd0, 32'hA5A55A5A};
        tbl[3] = '{K_WR,  24'h000000, 4'b1111, 32'h00000000, 32'h0,         1, 1'b0, 4'h0, 8'd0, 32'hA5A55A5A};
        tbl[4] = '{K_ERR, 24'h123456, 4'b0000, 32'h0,        32'h0,         3, 1'b0, 4'h0, 8'd1, 32'hA5A55A5A};
        tbl[5] = '{K_WR,  24'hFFFFFC, 4'b0110, 32'h0F0F0F0F, 32'h0,         2, 1'b1, 4'h9, 8'd1, 32'hA5A55A5A};

        rst = 1'b1; bus_as = 1'b0; bus_rs_n = 1'b1; bus_ws_n = 1'b1;
        bus_addr = '0; bus_be_n = '1; bus_din = '0; rf_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk32("rst dout", 0, bus_dout, 32'h0);
        chk1("rst doe", 0, bus_doe, 1'b0);
        chk1("rst dtack_n", 0, bus_dtack_n, 1'b1);
        chk32("rst rf_addr", 0, 32'(rf_addr), 32'h0);
        chk32("rst rf_be", 0, 32'(rf_be), 32'h0);
        chk32("rst rf_wdata", 0, rf_wdata, 32'h0);
        chk1("rst rf_wr", 0, rf_wr, 1'b0);
        chk1("rst rf_rd", 0, rf_rd, 1'b0);
        chk32("rst err_cnt", 0, 32'(err_cnt), 32'h0);
        chk1("rst busy", 0, busy, 1'b0);
        rst = 1'b0;
        idle_cycles(2);

        // Timeout on the TMO=8 instance while the default instance simply acknowledges.
        trd = 0;
        bus_addr = 24'h000100; bus_be_n = 4'b0000; rf_rdata = 32'hCAFE0001;
        bus_as = 1'b1; bus_rs_n = 1'b0; bus_ws_n = 1'b1;
        for (int i = 0; i <= 51; i++) begin
            @(posedge clk);
            #1;
            if (t_rf_rd) trd++;
            chk1("tmo dtack_n", i, t_bus_dtack_n, !(i >= 4 && i < 12));
            chk1("tmo doe", i, t_bus_doe, (i >= 4 && i < 12));
            chk1("tmo busy", i, t_busy, i < 50);
            chk32("tmo err_cnt", i, 32'(t_err_cnt), (i >= 12) ? 32'd1 : 32'd0);
            chk1("long dtack_n", i, bus_dtack_n, !(i >= 4 && i < 50));
            if (i == 49) begin
                bus_rs_n = 1'b1; bus_as = 1'b0;
            end
        end
        chk32("tmo rf_rd count", 0, 32'(trd), 32'd1);
        exp_dout = 32'hCAFE0001;
        idle_cycles(1);

        foreach (tbl[n]) begin
            run_txn(tbl[n].kind, tbl[n].addr, tbl[n].be_n, tbl[n].din, tbl[n].rdata,
                    tbl[n].hold, tbl[n].rel_as, tbl[n].exp_be);
            chk32("tbl err_cnt", n, 32'(err_cnt), 32'(tbl[n].exp_err));
            chk32("tbl dout", n, bus_dout, tbl[n].exp_dout);
        end

        for (int n = 0; n < 40; n++) begin
            int          kind, hold;
            logic [3:0]  be_n;
            kind = int'($urandom_range(0, 2));
            be_n = 4'($urandom);
            case (kind)
                K_RD:    hold = int'($urandom_range(RD_LAT + 3, RD_LAT + 14));
                K_WR:    hold = int'($urandom_range(1, 12));
                default: hold = int'($urandom_range(1, 6));
            endcase
            run_txn(kind, 24'($urandom), be_n, $urandom, $urandom, hold,
                    1'($urandom_range(0, 1)), ~be_n);
        end

        // Strobe left low across an as-only release must not restart a read.
        bus_addr = 24'h00ABCD; bus_be_n = 4'b0000; rf_rdata = 32'h0BADF00D;
        bus_as = 1'b1; bus_rs_n = 1'b0; bus_ws_n = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            @(posedge clk);
            #1;
            chk1("relow rf_rd", i, rf_rd, i == 0);
            chk1("relow busy", i, busy, i < 7);
            chk1("relow dtack_n", i, bus_dtack_n, !(i >= 4 && i < 7));
            if (i == 6) bus_as = 1'b0;
            if (i == 8) bus_as = 1'b1;
        end
        exp_dout = 32'h0BADF00D;
        idle_cycles(2);

        // Reset during RD_WAIT, strobe held low afterwards.
        bus_addr = 24'h000020; rf_rdata = 32'h55AA55AA;
        bus_as = 1'b1; bus_rs_n = 1'b0; bus_ws_n = 1'b1;
        @(posedge clk); #1;
        chk1("mid rf_rd", 0, rf_rd, 1'b1);
        @(posedge clk); #1;
        chk1("mid busy", 1, busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("mid rst busy", 2, busy, 1'b0);
        chk1("mid rst dtack_n", 2, bus_dtack_n, 1'b1);
        chk1("mid rst doe", 2, bus_doe, 1'b0);
        chk32("mid rst dout", 2, bus_dout, 32'h0);
        chk32("mid rst rf_addr", 2, 32'(rf_addr), 32'h0);
        chk32("mid rst err_cnt", 2, 32'(err_cnt), 32'h0);
        for (int i = 3; i < 13; i++) begin
            @(posedge clk); #1;
            chk1("post rst rf_rd", i, rf_rd, 1'b0);
            chk1("post rst busy", i, busy, 1'b0);
            chk1("post rst dtack_n", i, bus_dtack_n, 1'b1);
        end
        exp_err = 0; exp_dout = '0; exp_wdata = '0;
        idle_cycles(2);

        for (int n = 0; n < 300; n++) begin
            run_txn(K_ERR, 24'(n), 4'b0000, 32'h0, 32'h0, 1, 1'b0, 4'h0);
        end
        chk32("sat err_cnt", 300, 32'(err_cnt), 32'd255);

        // Fresh edge after saturation still works.
        run_txn(K_WR, 24'h000044, 4'b0011, 32'h01020304, 32'h0, 3, 1'b0, 4'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
